cc_speedcounter: RTL and testbench
==================================

Name: cc_speedcounter

Overview:
- Free-running tick-period counter that sits directly upstream of the speed comparator.
- Drives the comparator's data and limit buses and consumes its active-low match (T0) output to wrap.
- Emits a one-cycle tick per period; game logic uses it to step lane and obstacle movement.
- Period shortens with game level, with a floor clamp.

Parameters:
- DATAWIDTH, 16, width of count and limit buses (must equal the comparator's data width)
- LEVELWIDTH, 3, width of level input
- BASE_LIMIT, 50000, limit at level 0
- STEP_LIMIT, 5000, limit decrement per level
- MIN_LIMIT, 10000, floor for limit; must be >= 1

Ports:
- CC_SPEEDCOUNTER_CLOCK_50  in  1  system clock
- CC_SPEEDCOUNTER_RESET_InHigh  in  1  synchronous reset, active-high
- CC_SPEEDCOUNTER_enable_InHigh  in  1  game running; low pauses counting
- CC_SPEEDCOUNTER_T0_InLow  in  1  comparator match, 0 = data equals limit
- CC_SPEEDCOUNTER_level_InBUS  in  LEVELWIDTH  current game level
- CC_SPEEDCOUNTER_data_OutBUS  out  DATAWIDTH  count value to comparator data input
- CC_SPEEDCOUNTER_limit_OutBUS  out  DATAWIDTH  latched limit to comparator limit input
- CC_SPEEDCOUNTER_tick_OutHigh  out  1  one-cycle pulse per completed period

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- All outputs registered; state is sampled on the rising edge of CC_SPEEDCOUNTER_CLOCK_50.
- Reset values (the reset has priority over every other input):
  - data = 0
  - tick = 0
  - state = IDLE
  - limit = f(level input sampled at reset)
- Limit function f(lvl):
  - prod = lvl*STEP_LIMIT, computed at DATAWIDTH+LEVELWIDTH bits.
  - If prod > BASE_LIMIT, or BASE_LIMIT-prod < MIN_LIMIT, the result is MIN_LIMIT.
  - Otherwise the result is BASE_LIMIT-prod, truncated to DATAWIDTH.
- FSM states: IDLE, RUN, PAUSE.
- IDLE:
  - data held at 0, tick 0.
  - enable=1: go to RUN, limit <= f(level), data stays 0.
- RUN, evaluated in priority order:
  - (a) enable=0: go to PAUSE, data held, tick 0.
  - (b) T0_InLow=0: data <= 0, tick <= 1, limit <= f(level).
  - (c) otherwise: data <= data+1 (mod 2^DATAWIDTH), tick <= 0.
  - If enable=0 and T0=0 occur in the same cycle, (a) wins; the pending match is honoured on resume because data is unchanged.
- PAUSE:
  - data and limit held, tick 0.
  - enable=1: return to RUN and continue from the held data (no restart).
- Timing:
  - With a combinational comparator, data counts 0..L and the period is L+1 cycles.
  - tick is high in the cycle data returns to 0.
- Level changes mid-period are ignored until the next wrap; limit never changes except at a wrap, at the IDLE->RUN transition, or at reset.
- If T0 never asserts (comparator fault), data wraps all-ones -> 0 with no tick.
- Reset mid-RUN or mid-PAUSE: next cycle all outputs take their reset values and state is IDLE, regardless of enable.
- tick is never high for 2 consecutive cycles when MIN_LIMIT >= 1.

Test Plan (bench instantiates cc_speedcounter with a comparator model in loop; BASE_LIMIT=10, STEP_LIMIT=2, MIN_LIMIT=4, DATAWIDTH=8):
- Reset with level=0, enable=0 held 3 cycles -> data=0, tick=0, limit=10, data stays 0 in IDLE.
- enable=1, level=0 for 40 cycles -> data ramps 0..10; tick pulses every 11 cycles, first tick 12 cycles after enable rises; each tick is 1 cycle wide.
- Level changed 0->2 while data=5 -> current period still ends at data=10; limit becomes 6 at that wrap; next period is 7 cycles.
- level=7 (prod=14 > BASE) -> limit clamps to 4; period is 5 cycles.
- Drop enable at data=7 for 4 cycles, then raise it -> data holds 7 with no tick during the pause; counting resumes 8,9,10 and then ticks.
- Fault and reset cases:
  - T0 forced high -> data wraps 255->0 with no tick.
  - Assert reset at data=6 -> next cycle data=0, tick=0, state IDLE.

Source files
------------

// File: rtl/cc_speedcounter.sv
`default_nettype none
// ============================================================================
//  Module      : cc_speedcounter
//  Description : Free-running tick-period counter that drives an external
//                equality comparator (data/limit buses) and wraps when the
//                comparator reports a match on its active-low T0 output.
//                Emits a one-cycle tick per completed period. The period
//                limit shrinks with game level down to a floor.
//  Ports       : CC_SPEEDCOUNTER_CLOCK_50       - system clock
//                CC_SPEEDCOUNTER_RESET_InHigh   - synchronous reset, active-high
//                CC_SPEEDCOUNTER_enable_InHigh  - run (1) / pause (0)
//                CC_SPEEDCOUNTER_T0_InLow       - comparator match, 0 = equal
//                CC_SPEEDCOUNTER_level_InBUS    - current game level
//                CC_SPEEDCOUNTER_data_OutBUS    - count to comparator data
//                CC_SPEEDCOUNTER_limit_OutBUS   - latched limit to comparator
//                CC_SPEEDCOUNTER_tick_OutHigh   - one-cycle period pulse
//  Revision    : 1.0 - initial release
// ============================================================================
module cc_speedcounter #(
    parameter int DATAWIDTH  = 16,
    parameter int LEVELWIDTH = 3,
    parameter int BASE_LIMIT = 50000,
    parameter int STEP_LIMIT = 5000,
    parameter int MIN_LIMIT  = 10000
) (
    input  logic                  CC_SPEEDCOUNTER_CLOCK_50,
    input  logic                  CC_SPEEDCOUNTER_RESET_InHigh,
    input  logic                  CC_SPEEDCOUNTER_enable_InHigh,
    input  logic                  CC_SPEEDCOUNTER_T0_InLow,
    input  logic [LEVELWIDTH-1:0] CC_SPEEDCOUNTER_level_InBUS,
    output logic [DATAWIDTH-1:0]  CC_SPEEDCOUNTER_data_OutBUS,
    output logic [DATAWIDTH-1:0]  CC_SPEEDCOUNTER_limit_OutBUS,
    output logic                  CC_SPEEDCOUNTER_tick_OutHigh
);

    // Product width wide enough that level*STEP_LIMIT never overflows.
    localparam int PW = DATAWIDTH + LEVELWIDTH;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_PAUSE = 2'd2;

    localparam logic [PW-1:0]        C_BASE  = PW'(BASE_LIMIT);
    localparam logic [PW-1:0]        C_STEP  = PW'(STEP_LIMIT);
    localparam logic [PW-1:0]        C_MINW  = PW'(MIN_LIMIT);
    localparam logic [DATAWIDTH-1:0] C_MIN   = DATAWIDTH'(MIN_LIMIT);

    logic [1:0]           state_q, state_d;
    logic [DATAWIDTH-1:0] data_q,  data_d;
    logic [DATAWIDTH-1:0] limit_q, limit_d;
    logic                 tick_q,  tick_d;
    logic [DATAWIDTH-1:0] lim_new;

    // Level-to-limit mapping: BASE - level*STEP, clamped to the floor. The
    // overshoot test must come first so the subtraction never underflows.
    function automatic logic [DATAWIDTH-1:0] f_limit(input logic [LEVELWIDTH-1:0] lvl);
        logic [PW-1:0] prod;
        logic [PW-1:0] diff;
        prod = PW'(lvl) * C_STEP;
        diff = C_BASE - prod;
        if (prod > C_BASE) begin
            return C_MIN;
        end else if (diff < C_MINW) begin
            return C_MIN;
        end else begin
            return DATAWIDTH'(diff);
        end
    endfunction

    assign lim_new = f_limit(CC_SPEEDCOUNTER_level_InBUS);

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        limit_d = limit_q;
        tick_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                data_d = '0;
                if (CC_SPEEDCOUNTER_enable_InHigh) begin
                    state_d = S_RUN;
                    limit_d = lim_new;
                end
            end
            S_RUN: begin
                // Pause wins over a simultaneous match; data is held so the
                // match is seen again on resume.
                if (!CC_SPEEDCOUNTER_enable_InHigh) begin
                    state_d = S_PAUSE;
                end else if (!CC_SPEEDCOUNTER_T0_InLow) begin
                    data_d  = '0;
                    tick_d  = 1'b1;
                    limit_d = lim_new;
                end else begin
                    data_d  = data_q + 1'b1;
                end
            end
            S_PAUSE: begin
                if (CC_SPEEDCOUNTER_enable_InHigh) begin
                    state_d = S_RUN;
                end
            end
            default: begin
                state_d = S_IDLE;
                data_d  = '0;
            end
        endcase
    end

    always_ff @(posedge CC_SPEEDCOUNTER_CLOCK_50) begin
        if (CC_SPEEDCOUNTER_RESET_InHigh) begin
            state_q <= S_IDLE;
            data_q  <= '0;
            tick_q  <= 1'b0;
            limit_q <= lim_new;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            tick_q  <= tick_d;
            limit_q <= limit_d;
        end
    end

    assign CC_SPEEDCOUNTER_data_OutBUS  = data_q;
    assign CC_SPEEDCOUNTER_limit_OutBUS = limit_q;
    assign CC_SPEEDCOUNTER_tick_OutHigh = tick_q;

endmodule
`default_nettype wire

// File: tb/tb_cc_speedcounter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cc_speedcounter
//  Description : Bench for cc_speedcounter with an equality comparator in the
//                loop, a behavioural reference model, directed scenarios with
//                literal expectations and a randomized soak phase.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cc_speedcounter;

    localparam int DW = 8;
    localparam int LW = 3;
    localparam int BASE = 10;
    localparam int STEP = 2;
    localparam int MINL = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic          fault;
    logic [LW-1:0] level;
    logic          t0_n;
    logic [DW-1:0] data;
    logic [DW-1:0] limit;
    logic          tick;

    int n_pass = 0;
    int n_tot  = 0;
    bit cmp_on = 1'b0;

    always #5 clk = ~clk;

    // Combinational comparator; a fault holds its match output inactive.
    assign t0_n = fault | (data != limit);

    cc_speedcounter #(
        .DATAWIDTH (DW),
        .LEVELWIDTH(LW),
        .BASE_LIMIT(BASE),
        .STEP_LIMIT(STEP),
        .MIN_LIMIT (MINL)
    ) dut (
        .CC_SPEEDCOUNTER_CLOCK_50     (clk),
        .CC_SPEEDCOUNTER_RESET_InHigh (rst),
        .CC_SPEEDCOUNTER_enable_InHigh(en),
        .CC_SPEEDCOUNTER_T0_InLow     (t0_n),
        .CC_SPEEDCOUNTER_level_InBUS  (level),
        .CC_SPEEDCOUNTER_data_OutBUS  (data),
        .CC_SPEEDCOUNTER_limit_OutBUS (limit),
        .CC_SPEEDCOUNTER_tick_OutHigh (tick)
    );

    task automatic check(input string name, input int act, input int exp);
        n_tot++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // Plain-integer limit rule.
    function automatic int flim(input int lvl);
        int p;
        p = lvl * STEP;
        if (p > BASE || BASE - p < MINL) return MINL;
        return BASE - p;
    endfunction

    // Reference model: mode 0 stopped, 1 counting, 2 paused.
    int m_mode, m_cnt, m_lim, m_tick;
    always @(posedge clk) begin
        if (rst) begin
            m_mode = 0; m_cnt = 0; m_tick = 0; m_lim = flim(int'(level));
        end else begin
            m_tick = 0;
            if (m_mode == 0) begin
                if (en) begin m_mode = 1; m_lim = flim(int'(level)); end
            end else if (m_mode == 2) begin
                if (en) m_mode = 1;
            end else if (!en) begin
                m_mode = 2;
            end else if (!fault && m_cnt == m_lim) begin
                m_cnt = 0; m_tick = 1; m_lim = flim(int'(level));
            end else begin
                m_cnt = (m_cnt + 1) % (1 << DW);
            end
        end
    end

    int prev_tick = 0;
    always @(negedge clk) begin
        if (cmp_on) begin
            check("model_data",  int'(data),  m_cnt);
            check("model_limit", int'(limit), m_lim);
            check("model_tick",  int'(tick),  m_tick);
            check("tick_not_double", int'(prev_tick != 0 && tick), 0);
            prev_tick = int'(tick);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_tick(input int budget, output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (!tick && n < budget);
        if (!tick) check("wait_tick_timeout", 0, 1);
    endtask

    task automatic wait_data(input int val, input int budget);
        int n;
        n = 0;
        while (int'(data) != val && n < budget) begin
            step();
            n++;
        end
        if (int'(data) != val) check("wait_data_timeout", int'(data), val);
    endtask

    initial begin
        int n;
        rst = 1'b1; en = 1'b0; level = '0; fault = 1'b0;
        repeat (3) step();
        cmp_on = 1'b1;
        check("rst_data", int'(data), 0);
        check("rst_tick", int'(tick), 0);
        check("rst_limit", int'(limit), 10);
        rst = 1'b0;
        repeat (3) step();
        check("idle_data", int'(data), 0);

        // Level 0: first tick 12 cycles after enable, then period 11.
        en = 1'b1;
        wait_tick(30, n);
        check("first_tick_latency", n, 12);
        wait_tick(30, n);
        check("period_lvl0", n, 11);

        // Level change mid-period takes effect only at the wrap.
        wait_data(5, 30);
        level = 3'd2;
        wait_tick(30, n);
        check("finish_old_period", n, 6);
        check("limit_lvl2", int'(limit), 6);
        wait_tick(30, n);
        check("period_lvl2", n, 7);

        // Clamped level.
        level = 3'd7;
        wait_tick(30, n);
        check("finish_lvl2_period", n, 7);
        check("limit_lvl7", int'(limit), 4);
        wait_tick(30, n);
        check("period_lvl7", n, 5);

        // Pause at data=7 and resume.
        level = 3'd0;
        wait_tick(30, n);
        check("limit_back_lvl0", int'(limit), 10);
        wait_data(7, 30);
        en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            check("pause_data", int'(data), 7);
            check("pause_tick", int'(tick), 0);
        end
        en = 1'b1;
        step(); check("resume_data7", int'(data), 7);
        step(); check("resume_data8", int'(data), 8);
        step(); check("resume_data9", int'(data), 9);
        step(); check("resume_data10", int'(data), 10);
        step(); check("resume_tick", int'(tick), 1);
        check("resume_wrap", int'(data), 0);

        // Comparator fault: full-range wrap with no tick.
        fault = 1'b1;
        wait_data(255, 300);
        step();
        check("fault_wrap_data", int'(data), 0);
        check("fault_wrap_tick", int'(tick), 0);
        fault = 1'b0;

        // Reset mid-run returns to IDLE.
        wait_data(6, 300);
        rst = 1'b1;
        step();
        check("midrst_data", int'(data), 0);
        check("midrst_tick", int'(tick), 0);
        check("midrst_limit", int'(limit), 10);
        rst = 1'b0;
        step(); check("post_rst_idle_exit", int'(data), 0);
        step(); check("post_rst_count", int'(data), 1);

        // Randomized soak against the model.
        for (int i = 0; i < 3000; i++) begin
            rst   = ($urandom_range(0, 199) == 0);
            en    = ($urandom_range(0, 9) != 0);
            level = LW'($urandom_range(0, 7));
            if ($urandom_range(0, 399) == 0) fault = ~fault;
            step();
        end
        rst = 1'b0; fault = 1'b0; en = 1'b1;
        repeat (20) step();

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
